// File: rtl/jt_pkg.sv
// Shared types and reset-default contents for the jump target table.
package jt_pkg;

    typedef enum logic [1:0] {
        JT_ABS   = 2'd0,
        JT_LABEL = 2'd1,
        JT_REL   = 2'd2,
        JT_RSVD  = 2'd3
    } jt_mode_e;

    localparam int DEFAULT_VALID_CNT = 9;
    localparam int DEFAULT_LABELS [DEFAULT_VALID_CNT] = '{9, 19, 76, 101, 123, 131, 8, 37, 16};

    // Entries past the programmed defaults load as zero.
    function automatic int default_label(input int idx);
        int result;
        result = 0;
        for (int i = 0; i < DEFAULT_VALID_CNT; i++) begin
            if (i == idx) begin
                result = DEFAULT_LABELS[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jt_label_ram.sv
// Label table: per-entry target plus valid bit, write port, clear-sweep port
// and a write-through bypass on the combinational read port.
module jt_label_ram #(
    parameter  int PC_W  = 16,
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [PC_W-1:0]  wr_data_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [PC_W-1:0]  rd_data_o,
    output logic             rd_valid_o
);
    import jt_pkg::*;

    logic [PC_W-1:0]  entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
        logic [PC_W-1:0] data_q;
        logic            valid_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                data_q  <= PC_W'(default_label(gi));
                valid_q <= (gi < DEFAULT_VALID_CNT);
            end else if (clr_en_i && (clr_idx_i == IDX_W'(gi))) begin
                data_q  <= PC_W'(default_label(gi));
                valid_q <= (gi < DEFAULT_VALID_CNT);
            end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
                data_q  <= wr_data_i;
                valid_q <= 1'b1;
            end
        end

        assign entry_data[gi]  = data_q;
        assign entry_valid[gi] = valid_q;
    end

    // Same-cycle write to the read index returns the incoming data.
    always_comb begin
        if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
            rd_data_o  = wr_data_i;
            rd_valid_o = 1'b1;
        end else begin
            rd_data_o  = entry_data[rd_idx_i];
            rd_valid_o = entry_valid[rd_idx_i];
        end
    end

endmodule

// File: rtl/jump_target_table.sv
// Resolves jump targets (absolute, label-table, PC-relative) with one cycle
// latency; a clear request sweeps the label table back to its defaults.
module jump_target_table #(
    parameter  int PC_W  = 16,
    parameter  int DEPTH = 16,
    parameter  int OFF_W = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_mode_i,
    input  logic [PC_W-1:0]  abs_target_i,
    input  logic [IDX_W-1:0] label_idx_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [OFF_W-1:0] rel_offset_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [PC_W-1:0]  wr_data_i,
    input  logic             clr_req_i,
    output logic             tgt_valid_o,
    output logic [PC_W-1:0]  tgt_out_o,
    output logic             tgt_err_o
);
    import jt_pkg::*;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             tgt_valid_q;
    logic [PC_W-1:0]  tgt_out_q;
    logic             tgt_err_q;

    logic             idle;
    logic             req_fire;
    logic             wr_fire;
    logic [PC_W-1:0]  rd_data;
    logic             rd_valid;
    logic [PC_W-1:0]  tgt_d;
    logic             err_d;

    assign idle     = (state_q == ST_IDLE);
    assign req_fire = req_valid_i && idle;
    assign wr_fire  = wr_en_i && idle;

    jt_label_ram #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_label_ram (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .wr_en_i    (wr_fire),
        .wr_idx_i   (wr_idx_i),
        .wr_data_i  (wr_data_i),
        .clr_en_i   (state_q == ST_CLEAR),
        .clr_idx_i  (cnt_q),
        .rd_idx_i   (label_idx_i),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid)
    );

    always_comb begin
        tgt_d = '0;
        err_d = 1'b0;
        case (jt_mode_e'(req_mode_i))
            JT_ABS:   tgt_d = abs_target_i;
            JT_LABEL: begin
                if (rd_valid) begin
                    tgt_d = rd_data;
                end else begin
                    err_d = 1'b1;
                end
            end
            // Sign-extend the offset to PC width; overflow wraps silently.
            JT_REL:   tgt_d = pc_i + PC_W'($signed(rel_offset_i));
            default:  err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tgt_valid_q <= 1'b0;
            tgt_out_q   <= '0;
            tgt_err_q   <= 1'b0;
        end else begin
            tgt_valid_q <= req_fire;
            if (req_fire) begin
                tgt_out_q <= tgt_d;
                tgt_err_q <= err_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = idle;
    assign tgt_valid_o = tgt_valid_q;
    assign tgt_out_o   = tgt_out_q;
    assign tgt_err_o   = tgt_err_q;

endmodule

// File: tb/tb_jump_target_table.sv
// Directed-vector bench for jump_target_table with default parameters.
module tb_jump_target_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [15:0] abs_target;
    logic [3:0]  label_idx;
    logic [15:0] pc;
    logic [7:0]  rel_offset;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        tgt_valid;
    logic [15:0] tgt_out;
    logic        tgt_err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    jump_target_table dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_mode_i   (req_mode),
        .abs_target_i (abs_target),
        .label_idx_i  (label_idx),
        .pc_i         (pc),
        .rel_offset_i (rel_offset),
        .wr_en_i      (wr_en),
        .wr_idx_i     (wr_idx),
        .wr_data_i    (wr_data),
        .clr_req_i    (clr_req),
        .tgt_valid_o  (tgt_valid),
        .tgt_out_o    (tgt_out),
        .tgt_err_o    (tgt_err)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] abs_t;
        logic [3:0]  idx;
        logic [15:0] pcv;
        logic [7:0]  off;
        logic        wr;
        logic [3:0]  widx;
        logic [15:0] wdata;
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [1:0] mode, input logic [15:0] abs_t,
                                input logic [3:0] idx, input logic [15:0] pcv,
                                input logic [7:0] off, input logic wr,
                                input logic [3:0] widx, input logic [15:0] wdata,
                                input logic [15:0] exp_out, input logic exp_err);
        vec_t v;
        v.mode = mode; v.abs_t = abs_t; v.idx = idx; v.pcv = pcv; v.off = off;
        v.wr = wr; v.widx = widx; v.wdata = wdata; v.exp_out = exp_out; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_mode = 2'd0; abs_target = '0; label_idx = '0;
        pc = '0; rel_offset = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; clr_req = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] mode, input logic [15:0] abs_t,
                             input logic [3:0] idx, input logic [15:0] pcv, input logic [7:0] off);
        req_valid = 1'b1; req_mode = mode; abs_target = abs_t; label_idx = idx;
        pc = pcv; rel_offset = off;
    endtask

    task automatic label_read(input string name, input logic [3:0] idx,
                              input logic [15:0] exp_out, input logic exp_err);
        drive_req(2'd1, '0, idx, '0, '0);
        step();
        idle_inputs();
        chk({name, "_valid"}, tgt_valid, 1);
        chk({name, "_out"}, tgt_out, exp_out);
        chk({name, "_err"}, tgt_err, exp_err);
        $display("read idx %0d -> out %0d err %0b", idx, tgt_out, tgt_err);
    endtask

    initial begin
        int n;
        logic [15:0] b2b_out [4];
        logic        b2b_err [4];

        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst_valid", tgt_valid, 0);
        chk("rst_out", tgt_out, 0);
        chk("rst_err", tgt_err, 0);
        chk("rst_ready", req_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //                mode   abs      idx    pc       off    wr widx  wdata    exp_out  err
        vecs[0]  = mk(2'd1, 16'h0,    4'd2,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd76,   0);
        vecs[1]  = mk(2'd1, 16'h0,    4'd12, 16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd0,    1);
        vecs[2]  = mk(2'd0, 16'h1234, 4'd0,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'h1234, 0);
        vecs[3]  = mk(2'd2, 16'h0,    4'd0,  16'hFFFE, 8'h05, 0, 4'd0, 16'd0,   16'h0003, 0);
        vecs[4]  = mk(2'd2, 16'h0,    4'd0,  16'h0002, 8'hFC, 0, 4'd0, 16'd0,   16'hFFFE, 0);
        vecs[5]  = mk(2'd3, 16'h5555, 4'd2,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd0,    1);
        vecs[6]  = mk(2'd1, 16'h0,    4'd8,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd16,   0);
        vecs[7]  = mk(2'd1, 16'h0,    4'd5,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd131,  0);
        vecs[8]  = mk(2'd1, 16'h0,    4'd12, 16'h0,    8'h00, 1, 4'd12, 16'd200, 16'd200, 0);
        vecs[9]  = mk(2'd1, 16'h0,    4'd12, 16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd200,  0);
        vecs[10] = mk(2'd1, 16'h0,    4'd0,  16'h0,    8'h00, 1, 4'd0, 16'd55,  16'd55,   0);
        vecs[11] = mk(2'd1, 16'h0,    4'd0,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd55,   0);
        vecs[12] = mk(2'd1, 16'h0,    4'd3,  16'h0,    8'h00, 1, 4'd4, 16'd77,  16'd101,  0);
        vecs[13] = mk(2'd1, 16'h0,    4'd4,  16'h0,    8'h00, 0, 4'd0, 16'd0,   16'd77,   0);

        for (int i = 0; i < 14; i++) begin
            drive_req(vecs[i].mode, vecs[i].abs_t, vecs[i].idx, vecs[i].pcv, vecs[i].off);
            wr_en = vecs[i].wr; wr_idx = vecs[i].widx; wr_data = vecs[i].wdata;
            step();
            idle_inputs();
            chk($sformatf("vec%0d_valid", i), tgt_valid, 1);
            chk($sformatf("vec%0d_out", i), tgt_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_err", i), tgt_err, vecs[i].exp_err);
            $display("vec %0d mode %0d -> out 0x%04h err %0b", i, vecs[i].mode, tgt_out, tgt_err);
        end

        // No request: pulse drops, outputs hold.
        step();
        chk("hold_valid", tgt_valid, 0);
        chk("hold_out", tgt_out, 77);
        chk("hold_err", tgt_err, 0);
        $display("idle cycle -> valid %0b out %0d", tgt_valid, tgt_out);

        // Clear together with a request: request served, then 16 busy cycles.
        drive_req(2'd0, 16'h00AA, '0, '0, '0);
        clr_req = 1'b1;
        step();
        chk("clr_req_valid", tgt_valid, 1);
        chk("clr_req_out", tgt_out, 16'h00AA);
        drive_req(2'd1, '0, 4'd0, '0, '0);
        wr_en = 1'b1; wr_idx = 4'd1; wr_data = 16'd999;
        n = 0;
        while (!req_ready && n < 40) begin
            n++;
            step();
            chk($sformatf("clr_drop%0d", n), tgt_valid, 0);
        end
        idle_inputs();
        chk("clr_busy_cycles", n, 16);
        $display("clear busy for %0d cycles", n);
        label_read("clr_idx0", 4'd0, 16'd9, 0);
        label_read("clr_idx12", 4'd12, 16'd0, 1);
        label_read("clr_idx1", 4'd1, 16'd19, 0);
        label_read("clr_idx4", 4'd4, 16'd123, 0);

        // Reset five cycles into a clear sweep.
        wr_en = 1'b1; wr_idx = 4'd8; wr_data = 16'd500;
        step();
        idle_inputs();
        drive_req(2'd0, 16'h0BEE, '0, '0, '0);
        clr_req = 1'b1;
        step();
        idle_inputs();
        chk("pre_rst_out", tgt_out, 16'h0BEE);
        chk("pre_rst_ready", req_ready, 0);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", tgt_valid, 0);
        chk("mid_rst_out", tgt_out, 0);
        chk("mid_rst_err", tgt_err, 0);
        chk("mid_rst_ready", req_ready, 1);
        step();
        step();
        reset = 1'b0;
        step();
        chk("post_rst_ready", req_ready, 1);
        label_read("post_rst_idx8", 4'd8, 16'd16, 0);
        label_read("post_rst_idx0", 4'd0, 16'd9, 0);

        // Four back-to-back requests.
        b2b_out = '{16'h0011, 16'h0110, 16'd37, 16'd0};
        b2b_err = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive_req(2'd0, 16'h0011, '0, '0, '0);
                1: drive_req(2'd2, '0, '0, 16'h0100, 8'h10);
                2: drive_req(2'd1, '0, 4'd7, '0, '0);
                default: drive_req(2'd3, 16'hFFFF, '0, '0, '0);
            endcase
            step();
            chk($sformatf("b2b%0d_valid", i), tgt_valid, 1);
            chk($sformatf("b2b%0d_out", i), tgt_out, b2b_out[i]);
            chk($sformatf("b2b%0d_err", i), tgt_err, b2b_err[i]);
            $display("b2b %0d -> out 0x%04h err %0b", i, tgt_out, tgt_err);
        end
        idle_inputs();
        step();
        chk("b2b_end_valid", tgt_valid, 0);
        chk("b2b_end_err_hold", tgt_err, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/jump_target_table.md
JUMP_TARGET_TABLE -- requirements
Module: jump_target_table

Interface
REQ-001 Parameter PC_W, default 16, width of program-counter and target values.
REQ-002 Parameter DEPTH, default 16, number of label-table entries (power of two, min 4); IDX_W = clog2(DEPTH).
REQ-003 Parameter OFF_W, default 8, width of the signed relative-jump offset.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, reset is asynchronous and active-high.
REQ-006 Port req_valid, input, 1, target-resolution request strobe.
REQ-007 Port req_ready, output, 1, high when a request is accepted this cycle.
REQ-008 Port req_mode, input, 2, jump mode: 0 ABS, 1 LABEL, 2 REL, 3 reserved.
REQ-009 Port abs_target, input, PC_W, computed absolute target for ABS mode.
REQ-010 Port label_idx, input, IDX_W, table index for LABEL mode.
REQ-011 Port pc, input, PC_W, current PC for REL mode.
REQ-012 Port rel_offset, input, OFF_W, signed two's-complement offset for REL mode.
REQ-013 Port wr_en / wr_idx / wr_data, input, 1 / IDX_W / PC_W, label-table write port.
REQ-014 Port clr_req, input, 1, request to restore the whole table to defaults.
REQ-015 Port tgt_valid, output, 1, one-cycle pulse: tgt_out/tgt_err valid.
REQ-016 Port tgt_out, output, PC_W, resolved jump target.
REQ-017 Port tgt_err, output, 1, request was invalid (unprogrammed entry or reserved mode).

Function
REQ-018 Latency SHALL be exactly one cycle: a request accepted in cycle N yields tgt_valid=1 in cycle N+1 only.
REQ-019 ABS SHALL return abs_target unchanged.
REQ-020 LABEL SHALL return table[label_idx] if that entry's valid bit is set; otherwise tgt_out=0, tgt_err=1.
REQ-021 REL SHALL return (pc + sign-extended rel_offset) modulo 2^PC_W; wrap-around is silent, no error.
REQ-022 Reserved mode 3 SHALL return tgt_out=0, tgt_err=1.
REQ-023 A write SHALL update table[wr_idx] and set its valid bit at the clock edge; writes are accepted only in IDLE.
REQ-024 Write and LABEL read to the same index in the same cycle SHALL return wr_data (write-through bypass), tgt_err=0.
REQ-025 FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req; CLEAR steps a counter 0..DEPTH-1, one entry per cycle, then ->IDLE.
REQ-026 In CLEAR each entry SHALL be reloaded from the default table, valid bit = default-valid flag; clear takes exactly DEPTH cycles.
REQ-027 req_ready SHALL be 1 in IDLE, 0 in CLEAR; requests and writes presented while req_ready=0 are dropped, no tgt_valid.
REQ-028 clr_req asserted in CLEAR SHALL be ignored; clr_req together with a request in IDLE: request accepted, clear starts the next cycle.
REQ-029 When req_valid=0, tgt_valid SHALL be 0 next cycle and tgt_out/tgt_err SHALL hold their previous values.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, clear counter 0, tgt_valid 0, tgt_out 0, tgt_err 0.
REQ-031 reset SHALL load all entries with defaults in the same asserted period: entries 0..8 = 9, 19, 76, 101, 123, 131, 8, 37, 16 (valid); entries 9..DEPTH-1 = 0 (invalid).
REQ-032 reset asserted during CLEAR SHALL abort the sweep; after release the table holds full defaults.

Structure
REQ-033 A shared package jt_pkg SHALL hold the jump-mode enum (ABS, LABEL, REL, RSVD), the default-label constant array, and the default-valid count (9).
REQ-034 The table storage with its valid bits, write port and bypass SHALL be one sub-module, jt_label_ram; FSM and target arithmetic remain in the top level.

Verification
REQ-035 After reset, LABEL idx 2 -> next cycle tgt_valid=1, tgt_out=76, tgt_err=0; LABEL idx 12 -> tgt_out=0, tgt_err=1.
REQ-036 ABS abs_target=0x1234 -> tgt_out=0x1234; REL pc=0xFFFE, offset=+5 -> 0x0003; pc=0x0002, offset=-4 (0xFC) -> 0xFFFE.
REQ-037 Write idx 12 = 200 with LABEL idx 12 in the same cycle -> tgt_out=200, tgt_err=0; a later read of idx 12 -> 200.
REQ-038 Overwrite idx 0 = 55, pulse clr_req -> req_ready=0 for exactly 16 cycles, requests dropped; then idx 0 -> 9, idx 12 -> tgt_err=1.
REQ-039 Assert reset 5 cycles into CLEAR -> outputs 0 immediately, req_ready=1 after release, idx 8 -> 16.
REQ-040 Mode 3 request -> tgt_err=1, tgt_out=0; back-to-back requests on 4 consecutive cycles -> 4 consecutive tgt_valid pulses in order.
